cam_capture_ctrl: RTL and testbench

Frame-capture sequencer between the OV-camera pixel datapath and the dual-port frame buffer (160x120 RGB332, 19200 bytes).
- Arms capture on a start request, aligns to VSYNC, and can discard settling frames.
- Generates the frame-buffer write address and write enable from the datapath's pixel strobe.
- Checks line and frame geometry, and reports busy, done and error status to the SoC-side register bank.

---
 rtl/cam_capture_ctrl.sv | 143 ++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: VSYNC-aligned arming, frame-buffer write
// addressing and line/frame geometry checks for the OV camera path.
module cam_capture_ctrl #(
    parameter int AW          = 15,
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SKIP_FRAMES = 1
) (
    input  logic          CAM_pclk,
    input  logic          rst,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic          px_we,
    input  logic          start,
    input  logic          cont,
    input  logic          stop,
    input  logic          abort,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic          busy,
    output logic          done,
    output logic [7:0]    frame_cnt,
    output logic          err_width,
    output logic          err_height,
    output logic          err_ovf
);
    localparam logic [AW-1:0] NPIX = AW'(IMG_W * IMG_H);

    typedef enum logic [2:0] {
        IDLE, WAIT_VS, SKIP, CAPTURE, DONE
    } state_t;

    state_t state, state_d;

    logic        vsync_q, href_q, cont_r, stop_pend;
    logic [7:0]  skip_cnt;
    logic [15:0] px_cnt, line_cnt;
    logic        vs_fall, vs_rise, h_fall, in_cap, room;
    logic [16:0] eff;

    assign vs_fall = vsync_q & ~CAM_vsync;
    assign vs_rise = ~vsync_q & CAM_vsync;
    assign h_fall  = href_q & ~CAM_href;
    assign in_cap  = (state == CAPTURE);
    assign room    = (ram_addr < NPIX);
    assign ram_we  = in_cap & px_we & room;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    // A strobe coinciding with the line end still belongs to that line
    assign eff     = {1'b0, px_cnt} + {16'd0, px_we};

    always_ff @(posedge CAM_pclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (abort)        state_d = IDLE;
                else if (stop)    state_d = DONE;
                else if (vs_fall) state_d = (skip_cnt != 8'd0) ? SKIP : CAPTURE;
            end
            SKIP: begin
                if (abort)        state_d = IDLE;
                else if (stop)    state_d = DONE;
                else if (vs_rise) state_d = WAIT_VS;
            end
            CAPTURE: begin
                if (abort) state_d = IDLE;
                else if (vs_rise)
                    state_d = (!cont_r || stop_pend || stop) ? DONE : WAIT_VS;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CAM_pclk or posedge rst) begin
        if (rst) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            cont_r     <= 1'b0;
            stop_pend  <= 1'b0;
            skip_cnt   <= 8'd0;
            px_cnt     <= 16'd0;
            line_cnt   <= 16'd0;
            ram_addr   <= '0;
            frame_cnt  <= 8'd0;
            err_width  <= 1'b0;
            err_height <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            vsync_q <= CAM_vsync;
            href_q  <= CAM_href;

            if (state == IDLE && start) begin
                cont_r     <= cont;
                frame_cnt  <= 8'd0;
                err_width  <= 1'b0;
                err_height <= 1'b0;
                err_ovf    <= 1'b0;
                stop_pend  <= 1'b0;
                skip_cnt   <= 8'(SKIP_FRAMES);
            end

            if (state == SKIP && state_d == WAIT_VS)
                skip_cnt <= skip_cnt - 8'd1;

            if (state == WAIT_VS && state_d == CAPTURE) begin
                ram_addr <= '0;
                px_cnt   <= 16'd0;
                line_cnt <= 16'd0;
            end

            if (in_cap && !abort) begin
                if (stop) stop_pend <= 1'b1;

                if (px_we) begin
                    if (room) ram_addr <= ram_addr + 1'b1;
                    else      err_ovf  <= 1'b1;
                end

                if (h_fall) begin
                    if (eff != 17'(IMG_W)) err_width <= 1'b1;
                    px_cnt <= 16'd0;
                    if (line_cnt != 16'hFFFF) line_cnt <= line_cnt + 16'd1;
                end else if (px_we && px_cnt != 16'hFFFF) begin
                    px_cnt <= px_cnt + 16'd1;
                end

                if (vs_rise) begin
                    if (line_cnt != 16'(IMG_H)) err_height <= 1'b1;
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: full-size instance plus a
// small-geometry instance for the continuous/stop sequence.
module tb_cam_capture_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, vs, hr, pxw, start, cont, stop, abort, sel;

    logic        a_we, a_busy, a_done, a_errw, a_errh, a_erro;
    logic [14:0] a_addr;
    logic [7:0]  a_fcnt;
    logic        b_we, b_busy, b_done, b_errw, b_errh, b_erro;
    logic [5:0]  b_addr;
    logic [7:0]  b_fcnt;

    cam_capture_ctrl dut (
        .CAM_pclk(clk), .rst(rst), .CAM_vsync(vs), .CAM_href(hr),
        .px_we(pxw), .start(start & ~sel), .cont(cont), .stop(stop),
        .abort(abort), .ram_we(a_we), .ram_addr(a_addr), .busy(a_busy),
        .done(a_done), .frame_cnt(a_fcnt), .err_width(a_errw),
        .err_height(a_errh), .err_ovf(a_erro)
    );

    cam_capture_ctrl #(.AW(6), .IMG_W(8), .IMG_H(4), .SKIP_FRAMES(0)) dut_s (
        .CAM_pclk(clk), .rst(rst), .CAM_vsync(vs), .CAM_href(hr),
        .px_we(pxw), .start(start & sel), .cont(cont), .stop(stop),
        .abort(abort), .ram_we(b_we), .ram_addr(b_addr), .busy(b_busy),
        .done(b_done), .frame_cnt(b_fcnt), .err_width(b_errw),
        .err_height(b_errh), .err_ovf(b_erro)
    );

    int n_chk = 0;
    int n_pass = 0;

    int a_wr = 0, a_bad = 0, a_zero = 0, a_dn = 0;
    int b_wr = 0, b_bad = 0, b_zero = 0, b_dn = 0;
    logic [14:0] a_last = '0;
    logic [5:0]  b_last = '0;
    int w0, d0, z0;

    // Write monitors: each write must be at 0 or at previous address + 1
    always @(negedge clk) begin
        if (a_we) begin
            if (a_addr != 15'd0 && a_addr != a_last + 15'd1) a_bad <= a_bad + 1;
            if (a_addr == 15'd0) a_zero <= a_zero + 1;
            a_last <= a_addr;
            a_wr   <= a_wr + 1;
        end
        if (a_done) a_dn <= a_dn + 1;
        if (b_we) begin
            if (b_addr != 6'd0 && b_addr != b_last + 6'd1) b_bad <= b_bad + 1;
            if (b_addr == 6'd0) b_zero <= b_zero + 1;
            b_last <= b_addr;
            b_wr   <= b_wr + 1;
        end
        if (b_done) b_dn <= b_dn + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line(input int n);
        hr = 1'b1;
        repeat (n) begin
            pxw = 1'b1;
            tick();
            stop = 1'b0;
        end
        pxw = 1'b0;
        hr  = 1'b0;
        tick();
    endtask

    task automatic frame(input int lines, input int w, input int short_i,
                         input int stop_i);
        vs = 1'b0;
        tick(2);
        for (int i = 0; i < lines; i++) begin
            if (i == stop_i) stop = 1'b1;
            line((i == short_i) ? w - 1 : w);
            if (i == short_i) chk("short_line_werr", a_errw, 1);
        end
        vs = 1'b1;
        tick(2);
    endtask

    task automatic arm_and_skip();
        vs = 1'b1;
        tick(2);
        start = 1'b1;
        cont  = 1'b0;
        tick();
        start = 1'b0;
        vs = 1'b0;
        tick(2);
        line(10);
        vs = 1'b1;
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; vs = 1'b1; hr = 1'b0; pxw = 1'b0;
        start = 1'b0; cont = 1'b0; stop = 1'b0; abort = 1'b0; sel = 1'b0;
        tick(2);
        chk("rst_busy", a_busy, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_outs", {a_we, a_done, a_errw, a_errh, a_erro}, 0);
        chk("rst_fcnt", a_fcnt, 0);
        rst = 1'b0;
        tick(2);

        // Single frame, one settling frame discarded
        w0 = a_wr; d0 = a_dn; z0 = a_zero;
        arm_and_skip();
        chk("arm_busy", a_busy, 1);
        chk("skip_nowr", a_wr - w0, 0);
        frame(120, 160, -1, -1);
        chk("f1_writes", a_wr - w0, 19200);
        chk("f1_last", a_last, 19199);
        chk("f1_seq", a_bad, 0);
        chk("f1_zero", a_zero - z0, 1);
        chk("f1_done", a_dn - d0, 1);
        chk("f1_fcnt", a_fcnt, 1);
        chk("f1_errs", {a_errw, a_errh, a_erro}, 0);
        chk("f1_busy", a_busy, 0);

        // Short line 5
        d0 = a_dn;
        arm_and_skip();
        chk("short_clr", a_errw, 0);
        frame(120, 160, 5, -1);
        chk("short_errh", a_errh, 0);
        chk("short_erro", a_erro, 0);
        chk("short_done", a_dn - d0, 1);

        // 121 lines: overflow and height
        w0 = a_wr; d0 = a_dn;
        arm_and_skip();
        chk("ovf_clr", {a_errw, a_errh, a_erro}, 0);
        frame(121, 160, -1, -1);
        chk("ovf_flag", a_erro, 1);
        chk("ovf_writes", a_wr - w0, 19200);
        chk("ovf_last", a_last, 19199);
        chk("ovf_errh", a_errh, 1);
        chk("ovf_errw", a_errw, 0);
        chk("ovf_done", a_dn - d0, 1);

        // Continuous on the 8x4 instance, stop during frame 3
        sel = 1'b1;
        w0 = b_wr; d0 = b_dn; z0 = b_zero;
        start = 1'b1; cont = 1'b1;
        tick();
        start = 1'b0; cont = 1'b0;
        for (int f = 0; f < 3; f++) begin
            frame(4, 8, -1, (f == 2) ? 2 : -1);
            if (f < 2) begin
                chk("cont_busy", b_busy, 1);
                chk("cont_nodone", b_dn - d0, 0);
                chk("cont_fcnt", b_fcnt, f + 1);
            end
        end
        chk("cont_fcnt3", b_fcnt, 3);
        chk("cont_done", b_dn - d0, 1);
        chk("cont_writes", b_wr - w0, 96);
        chk("cont_restart", b_zero - z0, 3);
        chk("cont_seq", b_bad, 0);
        chk("cont_idle", b_busy, 0);
        chk("cont_errs", {b_errw, b_errh, b_erro}, 0);
        sel = 1'b0;

        // Abort in CAPTURE after 1000 pixels
        arm_and_skip();
        vs = 1'b0;
        tick(2);
        line(159);
        for (int l = 0; l < 5; l++) line(160);
        hr = 1'b1; pxw = 1'b1;
        tick(41);
        chk("abort_pre_addr", a_addr, 1000);
        d0 = a_dn;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_we", a_we, 0);
        chk("abort_busy", a_busy, 0);
        pxw = 1'b0; hr = 1'b0;
        tick(4);
        chk("abort_nodone", a_dn - d0, 0);
        chk("abort_errw_kept", a_errw, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rearm_busy", a_busy, 1);
        chk("rearm_errw", a_errw, 0);
        chk("rearm_fcnt", a_fcnt, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Async reset between edges, mid-frame
        arm_and_skip();
        vs = 1'b0;
        tick(2);
        line(160);
        hr = 1'b1; pxw = 1'b1;
        tick(20);
        chk("mid_addr", a_addr, 180);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", a_busy, 0);
        chk("arst_addr", a_addr, 0);
        chk("arst_outs", {a_we, a_done, a_errw, a_errh, a_erro}, 0);
        chk("arst_fcnt", a_fcnt, 0);
        rst = 1'b0;
        pxw = 1'b0; hr = 1'b0;
        tick();
        w0 = a_wr;
        arm_and_skip();
        vs = 1'b0;
        tick(2);
        line(10);
        chk("post_addr", a_addr, 10);
        chk("post_writes", a_wr - w0, 10);
        chk("post_busy", a_busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vs = 1'b1;
        tick(2);
        chk("seq_all", a_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
